// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / return sequencer for the EX stage.
//   A trap request saves the trapping PC and the cause into the special-register
//   write port, flushes the front end and vectors fetch to the handler. A reti in
//   the handler redirects fetch back to saved PC + 1. A stall freezes the
//   sequencer, including its outputs.
//
// Optional feature macro: TRAP_DOUBLE_FAULT_EN
//   defined   -> a trap request while in the handler is a double fault; the
//                sequencer halts until reset and performs no SR writes
//   undefined -> a trap request in the handler starts a fresh entry that
//                overwrites the saved PC and cause; HALT is never entered
//
// Ports:
//   iw_clk, iw_rst           clock, synchronous active-high reset
//   iw_trap_req/cause/pc     trap request from EX with cause code and PC
//   iw_reti                  return-from-trap executed in EX
//   iw_vec_base              trap vector table base
//   iw_stall                 pipeline stall, freezes state and outputs
//   ow_flush                 front-end flush
//   ow_redirect/_pc          fetch redirect strobe and target
//   ow_sr_we/_sel/_val       special-register write (sel 0 = saved PC, 1 = cause)
//   ow_in_trap               high in every state except IDLE
//   ow_halt                  double-fault halt (sticky until reset)
//   ow_cause                 last latched cause
module trap_ctrl (
    input  logic        iw_clk,
    input  logic        iw_rst,
    input  logic        iw_trap_req,
    input  logic [3:0]  iw_trap_cause,
    input  logic [47:0] iw_trap_pc,
    input  logic        iw_reti,
    input  logic [47:0] iw_vec_base,
    input  logic        iw_stall,
    output logic        ow_flush,
    output logic        ow_redirect,
    output logic [47:0] ow_redirect_pc,
    output logic        ow_sr_we,
    output logic [1:0]  ow_sr_sel,
    output logic [47:0] ow_sr_val,
    output logic        ow_in_trap,
    output logic        ow_halt,
    output logic [3:0]  ow_cause
);

    localparam int unsigned PC_W    = 48;
    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [SEL_W-1:0] SEL_PC    = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_CAUSE = SEL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SAVE_PC    = 3'd1,
        S_SAVE_CAUSE = 3'd2,
        S_REDIRECT   = 3'd3,
        S_HANDLER    = 3'd4,
        S_RETURN     = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_take;
    logic [PC_W-1:0]      r_pc;
    logic [CAUSE_W-1:0]   r_cause;
    logic [PC_W-1:0]      w_pc_next;
    logic [CAUSE_W-1:0]   w_cause_next;

    logic                 r_flush;
    logic                 r_redirect;
    logic [PC_W-1:0]      r_redirect_pc;
    logic                 r_sr_we;
    logic [SEL_W-1:0]     r_sr_sel;
    logic [PC_W-1:0]      r_sr_val;
    logic                 r_in_trap;
    logic                 r_halt;

    logic                 w_flush;
    logic                 w_redirect;
    logic [PC_W-1:0]      w_redirect_pc;
    logic                 w_sr_we;
    logic [SEL_W-1:0]     w_sr_sel;
    logic [PC_W-1:0]      w_sr_val;
    logic                 w_in_trap;
    logic                 w_halt;

    // State, latched trap context and registered outputs; stall freezes all of it.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_cause       <= '0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_sr_we       <= 1'b0;
            r_sr_sel      <= '0;
            r_sr_val      <= '0;
            r_in_trap     <= 1'b0;
            r_halt        <= 1'b0;
        end else if (!iw_stall) begin
            r_state       <= w_next;
            r_pc          <= w_pc_next;
            r_cause       <= w_cause_next;
            r_flush       <= w_flush;
            r_redirect    <= w_redirect;
            r_redirect_pc <= w_redirect_pc;
            r_sr_we       <= w_sr_we;
            r_sr_sel      <= w_sr_sel;
            r_sr_val      <= w_sr_val;
            r_in_trap     <= w_in_trap;
            r_halt        <= w_halt;
        end
    end

    // Next state; w_take marks the edge that captures a new trap context.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iw_trap_req) begin
                    w_next = S_SAVE_PC;
                    w_take = 1'b1;
                end
            end
            S_SAVE_PC:    w_next = S_SAVE_CAUSE;
            S_SAVE_CAUSE: w_next = S_REDIRECT;
            S_REDIRECT:   w_next = S_HANDLER;
            S_HANDLER: begin
                // A new trap outranks a simultaneous reti.
                if (iw_trap_req) begin
`ifdef TRAP_DOUBLE_FAULT_EN
                    w_next = S_HALT;
`else
                    w_next = S_SAVE_PC;
                    w_take = 1'b1;
`endif
                end else if (iw_reti) begin
                    w_next = S_RETURN;
                end
            end
            S_RETURN:     w_next = S_IDLE;
            S_HALT:       w_next = S_HALT;
            default:      w_next = S_IDLE;
        endcase
    end

    assign w_pc_next    = w_take ? iw_trap_pc    : r_pc;
    assign w_cause_next = w_take ? iw_trap_cause : r_cause;

    // Outputs decoded from the state being entered, so they register with it.
    always_comb begin
        w_flush       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_sr_we       = 1'b0;
        w_sr_sel      = SEL_PC;
        w_sr_val      = '0;
        w_in_trap     = (w_next != S_IDLE);
        w_halt        = 1'b0;
        case (w_next)
            S_SAVE_PC: begin
                w_flush  = 1'b1;
                w_sr_we  = 1'b1;
                w_sr_sel = SEL_PC;
                w_sr_val = w_pc_next;
            end
            S_SAVE_CAUSE: begin
                w_flush  = 1'b1;
                w_sr_we  = 1'b1;
                w_sr_sel = SEL_CAUSE;
                w_sr_val = PC_W'(w_cause_next);
            end
            S_REDIRECT: begin
                // Vector table entries are 4 apart; the sum wraps at 48 bits.
                w_flush       = 1'b1;
                w_redirect    = 1'b1;
                w_redirect_pc = iw_vec_base + PC_W'({w_cause_next, 2'b00});
            end
            S_RETURN: begin
                w_flush       = 1'b1;
                w_redirect    = 1'b1;
                w_redirect_pc = w_pc_next + PC_W'(1);
            end
            S_HALT: begin
                w_flush = 1'b1;
                w_halt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ow_flush       = r_flush;
    assign ow_redirect    = r_redirect;
    assign ow_redirect_pc = r_redirect_pc;
    assign ow_sr_we       = r_sr_we;
    assign ow_sr_sel      = r_sr_sel;
    assign ow_sr_val      = r_sr_val;
    assign ow_in_trap     = r_in_trap;
    assign ow_halt        = r_halt;
    assign ow_cause       = r_cause;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl.
//   A queue-based model predicts the outputs of every cycle: accepting a trap
//   queues the three entry cycles, a reti queues the return cycle, and when the
//   queue is empty the outputs follow the resting mode (idle, handler, halt).
//   Literal checks in the stimulus pin the model to hand-computed values.
//   Honors TRAP_DOUBLE_FAULT_EN the same way the design does.
module tb_trap_ctrl;

    logic        iw_clk        = 1'b0;
    logic        iw_rst        = 1'b1;
    logic        iw_trap_req   = 1'b0;
    logic [3:0]  iw_trap_cause = '0;
    logic [47:0] iw_trap_pc    = '0;
    logic        iw_reti       = 1'b0;
    logic [47:0] iw_vec_base   = 48'h1000;
    logic        iw_stall      = 1'b0;
    logic        ow_flush;
    logic        ow_redirect;
    logic [47:0] ow_redirect_pc;
    logic        ow_sr_we;
    logic [1:0]  ow_sr_sel;
    logic [47:0] ow_sr_val;
    logic        ow_in_trap;
    logic        ow_halt;
    logic [3:0]  ow_cause;

    int n_cmp  = 0;
    int n_fail = 0;

    trap_ctrl dut (
        .iw_clk         (iw_clk),
        .iw_rst         (iw_rst),
        .iw_trap_req    (iw_trap_req),
        .iw_trap_cause  (iw_trap_cause),
        .iw_trap_pc     (iw_trap_pc),
        .iw_reti        (iw_reti),
        .iw_vec_base    (iw_vec_base),
        .iw_stall       (iw_stall),
        .ow_flush       (ow_flush),
        .ow_redirect    (ow_redirect),
        .ow_redirect_pc (ow_redirect_pc),
        .ow_sr_we       (ow_sr_we),
        .ow_sr_sel      (ow_sr_sel),
        .ow_sr_val      (ow_sr_val),
        .ow_in_trap     (ow_in_trap),
        .ow_halt        (ow_halt),
        .ow_cause       (ow_cause)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct packed {
        logic        flush;
        logic        redirect;
        logic [47:0] rpc;
        logic        sr_we;
        logic [1:0]  sel;
        logic [47:0] srval;
        logic        in_trap;
        logic        halt;
        logic [3:0]  cause;
    } obs_t;

    localparam int M_IDLE    = 0;
    localparam int M_HANDLER = 1;
    localparam int M_HALT    = 2;

    // Model state: pending transient cycles plus the resting mode.
    obs_t        q[$];
    int          mode    = M_IDLE;
    logic [47:0] m_pc    = '0;
    logic [3:0]  m_cause = '0;
    bit          started = 1'b0;

    function automatic obs_t mk(input logic fl, input logic rd, input logic [47:0] rpc,
                                input logic we, input logic [1:0] sel,
                                input logic [47:0] sv, input logic it, input logic h);
        obs_t o;
        o.flush    = fl;
        o.redirect = rd;
        o.rpc      = rpc;
        o.sr_we    = we;
        o.sel      = sel;
        o.srval    = sv;
        o.in_trap  = it;
        o.halt     = h;
        o.cause    = '0;
        return o;
    endfunction

    function automatic obs_t expected();
        obs_t e;
        if (q.size() != 0)        e = q[0];
        else if (mode == M_HALT)  e = mk(1'b1, 1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1);
        else if (mode == M_HANDLER) e = mk(1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        else                      e = mk(1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
        e.cause = m_cause;
        return e;
    endfunction

    // Model advance on each active edge.
    always @(posedge iw_clk) begin
        obs_t tmp;
        if (iw_rst) begin
            q.delete();
            mode    = M_IDLE;
            m_pc    = '0;
            m_cause = '0;
            started = 1'b1;
        end else if (!iw_stall) begin
            if (q.size() != 0) begin
                tmp = q.pop_front();
            end else if (iw_trap_req && mode != M_HALT) begin
`ifdef TRAP_DOUBLE_FAULT_EN
                if (mode == M_HANDLER) begin
                    mode = M_HALT;
                end else begin
`else
                begin
`endif
                    m_pc    = iw_trap_pc;
                    m_cause = iw_trap_cause;
                    q.push_back(mk(1'b1, 1'b0, '0, 1'b1, 2'd0, iw_trap_pc, 1'b1, 1'b0));
                    q.push_back(mk(1'b1, 1'b0, '0, 1'b1, 2'd1, 48'(iw_trap_cause), 1'b1, 1'b0));
                    q.push_back(mk(1'b1, 1'b1, iw_vec_base + 48'(iw_trap_cause) * 48'd4,
                                   1'b0, 2'd0, '0, 1'b1, 1'b0));
                    mode = M_HANDLER;
                end
            end else if (iw_reti && mode == M_HANDLER) begin
                q.push_back(mk(1'b1, 1'b1, m_pc + 48'd1, 1'b0, 2'd0, '0, 1'b1, 1'b0));
                mode = M_IDLE;
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge iw_clk) begin
        obs_t e;
        obs_t a;
        if (started) begin
            e = expected();
            a.flush    = ow_flush;
            a.redirect = ow_redirect;
            a.rpc      = ow_redirect_pc;
            a.sr_we    = ow_sr_we;
            a.sel      = ow_sr_sel;
            a.srval    = ow_sr_val;
            a.in_trap  = ow_in_trap;
            a.halt     = ow_halt;
            a.cause    = ow_cause;
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model t=%0t got fl=%b rd=%b rpc=%h we=%b sel=%0d val=%h it=%b h=%b c=%h want fl=%b rd=%b rpc=%h we=%b sel=%0d val=%h it=%b h=%b c=%h",
                         $time, a.flush, a.redirect, a.rpc, a.sr_we, a.sel, a.srval, a.in_trap, a.halt, a.cause,
                         e.flush, e.redirect, e.rpc, e.sr_we, e.sel, e.srval, e.in_trap, e.halt, e.cause);
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iw_clk);
        #1;
    endtask

    task automatic raise(input logic [3:0] c, input logic [47:0] pc);
        iw_trap_req   = 1'b1;
        iw_trap_cause = c;
        iw_trap_pc    = pc;
        step(1);
        iw_trap_req   = 1'b0;
        iw_trap_cause = '0;
        iw_trap_pc    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        iw_rst = 1'b1;
        step(3);
        chk1("rst_flush", ow_flush, 1'b0);
        chk1("rst_in_trap", ow_in_trap, 1'b0);
        chk48("rst_cause", 48'(ow_cause), 48'd0);
        iw_rst = 1'b0;
        step(1);

        // reti in IDLE is ignored
        iw_reti = 1'b1;
        step(1);
        iw_reti = 1'b0;
        chk1("idle_reti_redirect", ow_redirect, 1'b0);
        chk1("idle_reti_in_trap", ow_in_trap, 1'b0);

        // Basic entry: cause 3, pc 0x400, base 0x1000
        raise(4'd3, 48'h400);
        chk1("save_pc_we", ow_sr_we, 1'b1);
        chk48("save_pc_sel", 48'(ow_sr_sel), 48'd0);
        chk48("save_pc_val", ow_sr_val, 48'h400);
        chk1("save_pc_flush", ow_flush, 1'b1);
        step(1);
        chk48("save_cause_sel", 48'(ow_sr_sel), 48'd1);
        chk48("save_cause_val", ow_sr_val, 48'd3);
        step(1);
        chk1("vec_redirect", ow_redirect, 1'b1);
        chk48("vec_pc", ow_redirect_pc, 48'h100C);
        chk1("vec_we", ow_sr_we, 1'b0);
        step(1);
        chk1("handler_in_trap", ow_in_trap, 1'b1);
        chk1("handler_redirect", ow_redirect, 1'b0);
        chk1("handler_flush", ow_flush, 1'b0);

        // Return to saved PC + 1
        iw_reti = 1'b1;
        step(1);
        iw_reti = 1'b0;
        chk1("ret_redirect", ow_redirect, 1'b1);
        chk48("ret_pc", ow_redirect_pc, 48'h401);
        chk1("ret_flush", ow_flush, 1'b1);
        step(1);
        chk1("ret_idle_in_trap", ow_in_trap, 1'b0);
        chk1("ret_idle_redirect", ow_redirect, 1'b0);

        // Stall in SAVE_CAUSE; trap_req held high must not disturb the entry
        iw_trap_req   = 1'b1;
        iw_trap_cause = 4'd2;
        iw_trap_pc    = 48'h800;
        step(1);
        iw_trap_cause = 4'd7;
        iw_trap_pc    = 48'h999;
        chk48("st_save_pc_val", ow_sr_val, 48'h800);
        step(1);
        chk48("st_save_cause_val", ow_sr_val, 48'd2);
        iw_stall = 1'b1;
        step(1);
        chk1("st_hold1_we", ow_sr_we, 1'b1);
        chk48("st_hold1_val", ow_sr_val, 48'd2);
        chk1("st_hold1_redirect", ow_redirect, 1'b0);
        step(1);
        chk1("st_hold2_we", ow_sr_we, 1'b1);
        chk1("st_hold2_redirect", ow_redirect, 1'b0);
        iw_stall = 1'b0;
        step(1);
        iw_trap_req = 1'b0;
        chk1("st_vec_redirect", ow_redirect, 1'b1);
        chk48("st_vec_pc", ow_redirect_pc, 48'h1008);
        step(1);
        chk48("st_handler_cause", 48'(ow_cause), 48'd2);
        iw_trap_cause = '0;
        iw_trap_pc    = '0;
        iw_reti = 1'b1;
        step(1);
        iw_reti = 1'b0;
        chk48("st_ret_pc", ow_redirect_pc, 48'h801);
        step(1);

        // Reset during REDIRECT, together with stall
        raise(4'd1, 48'h10);
        step(2);
        chk1("abort_pre_redirect", ow_redirect, 1'b1);
        chk48("abort_pre_pc", ow_redirect_pc, 48'h1004);
        iw_rst   = 1'b1;
        iw_stall = 1'b1;
        step(1);
        iw_rst   = 1'b0;
        iw_stall = 1'b0;
        chk1("abort_redirect", ow_redirect, 1'b0);
        chk1("abort_flush", ow_flush, 1'b0);
        chk1("abort_in_trap", ow_in_trap, 1'b0);
        chk48("abort_rpc", ow_redirect_pc, 48'd0);
        chk48("abort_cause", 48'(ow_cause), 48'd0);
        step(2);
        chk1("abort_later_we", ow_sr_we, 1'b0);
        chk1("abort_later_redirect", ow_redirect, 1'b0);

        // PC wrap on return
        raise(4'd0, 48'hFFFF_FFFF_FFFF);
        chk48("wrap_save_val", ow_sr_val, 48'hFFFF_FFFF_FFFF);
        step(3);
        chk1("wrap_handler", ow_in_trap, 1'b1);
        iw_reti = 1'b1;
        step(1);
        iw_reti = 1'b0;
        chk1("wrap_redirect", ow_redirect, 1'b1);
        chk48("wrap_pc", ow_redirect_pc, 48'd0);
        step(1);

        // Trap in HANDLER together with reti: trap path wins
        raise(4'd3, 48'h400);
        step(3);
        iw_reti = 1'b1;
        raise(4'd5, 48'h500);
        iw_reti = 1'b0;
`ifdef TRAP_DOUBLE_FAULT_EN
        chk1("df_halt", ow_halt, 1'b1);
        chk1("df_flush", ow_flush, 1'b1);
        chk1("df_we", ow_sr_we, 1'b0);
        chk1("df_redirect", ow_redirect, 1'b0);
        chk48("df_cause", 48'(ow_cause), 48'd3);
        iw_reti     = 1'b1;
        iw_trap_req = 1'b1;
        step(3);
        iw_reti     = 1'b0;
        iw_trap_req = 1'b0;
        chk1("df_sticky_halt", ow_halt, 1'b1);
        chk1("df_sticky_we", ow_sr_we, 1'b0);
        iw_rst = 1'b1;
        step(1);
        iw_rst = 1'b0;
        chk1("df_rst_halt", ow_halt, 1'b0);
`else
        chk1("nf_we", ow_sr_we, 1'b1);
        chk48("nf_sel", 48'(ow_sr_sel), 48'd0);
        chk48("nf_val", ow_sr_val, 48'h500);
        chk1("nf_halt", ow_halt, 1'b0);
        chk1("nf_redirect", ow_redirect, 1'b0);
        step(1);
        chk48("nf_cause_val", ow_sr_val, 48'd5);
        step(1);
        chk1("nf_vec_redirect", ow_redirect, 1'b1);
        chk48("nf_vec_pc", ow_redirect_pc, 48'h1014);
        step(1);
        chk48("nf_handler_cause", 48'(ow_cause), 48'd5);
        chk1("nf_handler_halt", ow_halt, 1'b0);
        iw_reti = 1'b1;
        step(1);
        iw_reti = 1'b0;
        chk48("nf_ret_pc", ow_redirect_pc, 48'h501);
        step(1);
        chk1("nf_idle", ow_in_trap, 1'b0);
`endif
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
